rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter.sv | 105 ++++++++++
 tb/tb_rf_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter for the register file's single write port.
// Source A has fixed priority; a bounded wait counter forces a grant to B.
module rf_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [4:0]        a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [4:0]        b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  wait_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc_wait(input logic [CNT_W-1:0] cnt);
        if (cnt >= MAX_WAIT_C) return MAX_WAIT_C;
        return cnt + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_drop(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX_C) return CNT_MAX_C;
        return cnt + 1'b1;
    endfunction

    logic              rf_we_q,    rf_we_d;
    logic [4:0]        rf_rd_q,    rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              grant_a;
    logic              grant_b;
    logic              xfer;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Grant: B wins when A is idle or B has waited MAX_WAIT cycles
    always_comb begin
        grant_b  = b_valid & (~a_valid | (wait_cnt_q >= MAX_WAIT_C));
        grant_a  = a_valid & ~grant_b;
        a_ready  = grant_a & ~reset;
        b_ready  = grant_b & ~reset;
        xfer     = (grant_a | grant_b) & ~reset;
        sel_rd   = grant_b ? b_rd   : a_rd;
        sel_data = grant_b ? b_data : a_data;
    end

    // Next state: x0 transfers are accepted but only bump drop_cnt
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        drop_cnt_d = drop_cnt_q;
        wait_cnt_d = '0;

        if (xfer) begin
            if (sel_rd != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_rd_d    = sel_rd;
                rf_wdata_d = sel_data;
            end else begin
                drop_cnt_d = sat_inc_drop(drop_cnt_q);
            end
        end

        if (b_valid & ~grant_b)
            wait_cnt_d = sat_inc_wait(wait_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            wait_cnt_q <= wait_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign wait_cnt = wait_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: default instance plus a MAX_WAIT=1 instance.
module tb_rf_write_arbiter;

    localparam int DW = 64;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_valid, b_valid, a_ready, b_ready, rf_we;
    logic [4:0]    a_rd, b_rd, rf_rd;
    logic [DW-1:0] a_data, b_data, rf_wdata;
    logic [CW-1:0] wait_cnt, drop_cnt;

    logic          m_a_valid, m_b_valid, m_a_ready, m_b_ready, m_rf_we;
    logic [4:0]    m_a_rd, m_b_rd, m_rf_rd;
    logic [DW-1:0] m_a_data, m_b_data, m_rf_wdata;
    logic [CW-1:0] m_wait_cnt, m_drop_cnt;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.DATA_W(DW), .MAX_WAIT(3), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .wait_cnt(wait_cnt), .drop_cnt(drop_cnt)
    );

    rf_write_arbiter #(.DATA_W(DW), .MAX_WAIT(1), .CNT_W(CW)) u_mw1 (
        .clk(clk), .reset(reset),
        .a_valid(m_a_valid), .a_rd(m_a_rd), .a_data(m_a_data), .a_ready(m_a_ready),
        .b_valid(m_b_valid), .b_rd(m_b_rd), .b_data(m_b_data), .b_ready(m_b_ready),
        .rf_we(m_rf_we), .rf_rd(m_rf_rd), .rf_wdata(m_rf_wdata),
        .wait_cnt(m_wait_cnt), .drop_cnt(m_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        m_a_valid = 0; m_a_rd = 0; m_a_data = 0;
        m_b_valid = 0; m_b_rd = 0; m_b_data = 0;

        tick(); tick();
        a_valid = 1; b_valid = 1;
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_wait", wait_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        tick();
        a_valid = 0; b_valid = 0; reset = 1'b0;

        // Single A write
        a_valid = 1; a_rd = 5; a_data = 64'hAA;
        @(negedge clk);
        chk("t1_a_ready", a_ready, 1);
        chk("t1_b_ready", b_ready, 0);
        tick();
        a_valid = 0;
        @(negedge clk);
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_rd", rf_rd, 5);
        chk("t1_rf_wdata", rf_wdata, 64'hAA);
        chk("t1_a_ready_idle", a_ready, 0);
        tick();
        @(negedge clk);
        chk("t1_rf_we_off", rf_we, 0);
        chk("t1_rf_rd_hold", rf_rd, 5);
        tick();

        // A and B continuously valid: 3 A grants then 1 B grant
        a_valid = 1; a_rd = 1; a_data = 64'h11;
        b_valid = 1; b_rd = 2; b_data = 64'h22;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2_a_ready_%0d", k), a_ready, (k % 4) != 3);
            chk($sformatf("t2_b_ready_%0d", k), b_ready, (k % 4) == 3);
            chk($sformatf("t2_wait_%0d", k), wait_cnt, k % 4);
            chk($sformatf("t2_rf_we_%0d", k), rf_we, k >= 1);
            if (k >= 1) begin
                chk($sformatf("t2_rf_rd_%0d", k), rf_rd, ((k - 1) % 4 == 3) ? 2 : 1);
                chk($sformatf("t2_rf_wdata_%0d", k), rf_wdata, ((k - 1) % 4 == 3) ? 64'h22 : 64'h11);
            end
            tick();
        end
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        chk("t2_last_rf_rd", rf_rd, 2);
        chk("t2_last_rf_wdata", rf_wdata, 64'h22);
        chk("t2_wait_clear", wait_cnt, 0);
        tick();

        // B alone is granted immediately
        b_valid = 1; b_rd = 7; b_data = 64'h77;
        @(negedge clk);
        chk("t3_b_ready", b_ready, 1);
        chk("t3_wait", wait_cnt, 0);
        tick();
        b_valid = 0;
        @(negedge clk);
        chk("t3_rf_we", rf_we, 1);
        chk("t3_rf_rd", rf_rd, 7);
        chk("t3_rf_wdata", rf_wdata, 64'h77);
        chk("t3_wait_after", wait_cnt, 0);
        tick();

        // x0 write is accepted and dropped; drop_cnt saturates at 15
        a_valid = 1; a_rd = 0; a_data = 64'hFF;
        @(negedge clk);
        chk("t4_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        @(negedge clk);
        chk("t4_rf_we", rf_we, 0);
        chk("t4_drop", drop_cnt, 1);
        chk("t4_rf_rd_hold", rf_rd, 7);
        chk("t4_rf_wdata_hold", rf_wdata, 64'h77);
        tick();
        a_valid = 1;
        repeat (15) tick();
        a_valid = 0;
        @(negedge clk);
        chk("t4_drop_sat", drop_cnt, 15);
        chk("t4_rf_we_sat", rf_we, 0);
        tick();

        // MAX_WAIT=1, same rd on both sources
        m_a_valid = 1; m_a_rd = 9; m_a_data = 64'h1;
        m_b_valid = 1; m_b_rd = 9; m_b_data = 64'h2;
        @(negedge clk);
        chk("t5_a_ready0", m_a_ready, 1);
        chk("t5_b_ready0", m_b_ready, 0);
        chk("t5_wait0", m_wait_cnt, 0);
        tick();
        m_a_data = 64'h3;
        @(negedge clk);
        chk("t5_a_ready1", m_a_ready, 0);
        chk("t5_b_ready1", m_b_ready, 1);
        chk("t5_wait1", m_wait_cnt, 1);
        chk("t5_rf_we1", m_rf_we, 1);
        chk("t5_rf_rd1", m_rf_rd, 9);
        chk("t5_rf_wdata1", m_rf_wdata, 64'h1);
        tick();
        m_b_valid = 0;
        @(negedge clk);
        chk("t5_a_ready2", m_a_ready, 1);
        chk("t5_wait2", m_wait_cnt, 0);
        chk("t5_rf_wdata2", m_rf_wdata, 64'h2);
        tick();
        m_a_valid = 0;
        @(negedge clk);
        chk("t5_rf_we3", m_rf_we, 1);
        chk("t5_rf_wdata3", m_rf_wdata, 64'h3);
        tick();

        // Reset right after an A transfer while B stays valid
        a_valid = 1; a_rd = 4; a_data = 64'h44;
        b_valid = 1; b_rd = 6; b_data = 64'h66;
        @(negedge clk);
        chk("t6_a_ready", a_ready, 1);
        chk("t6_b_ready", b_ready, 0);
        tick();
        a_valid = 0; reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_a_ready", a_ready, 0);
        chk("t6_rst_b_ready", b_ready, 0);
        chk("t6_wait_pre", wait_cnt, 1);
        tick();
        @(negedge clk);
        chk("t6_rst_rf_we", rf_we, 0);
        chk("t6_rst_wait", wait_cnt, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_rf_rd", rf_rd, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_b_ready_post", b_ready, 1);
        chk("t6_rf_we_post", rf_we, 0);
        tick();
        b_valid = 0;
        @(negedge clk);
        chk("t6_rf_we_b", rf_we, 1);
        chk("t6_rf_rd_b", rf_rd, 6);
        chk("t6_rf_wdata_b", rf_wdata, 64'h66);
        tick();
        @(negedge clk);
        chk("t6_rf_we_end", rf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
